// File: rtl/lse_simd_4x6b_feeder.sv
// lse_simd_4x6b_feeder
// Packs a serial stream of 6-bit operand pairs into four-lane X/Y words for the
// SIMD LSE unit. Groups close on a full word, end-of-stream, a pe_mode change or
// an idle timeout; unused lanes are filled with the most-negative log value.
module lse_simd_4x6b_feeder #(
    parameter int                        CHANNEL_WIDTH = 6,
    parameter int                        LANES         = 4,
    parameter int                        DATA_WIDTH    = CHANNEL_WIDTH * LANES,
    parameter logic [CHANNEL_WIDTH-1:0]  PAD_VALUE     = 6'b100000,
    parameter int                        IDLE_TIMEOUT  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHANNEL_WIDTH-1:0] in_a,
    input  logic [CHANNEL_WIDTH-1:0] in_b,
    input  logic [1:0]               in_mode,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    x_out,
    output logic [DATA_WIDTH-1:0]    y_out,
    output logic [LANES-1:0]         lane_mask,
    output logic [1:0]               mode_out
);

    localparam int                CNT_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LANES - 1);
    localparam int                TMR_W    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
    localparam bit                TMR_EN   = (IDLE_TIMEOUT > 0);

    // Assembly state
    logic [DATA_WIDTH-1:0] r_asm_x;
    logic [DATA_WIDTH-1:0] r_asm_y;
    logic [LANES-1:0]      r_asm_mask;
    logic [1:0]            r_asm_mode;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_pending;
    logic [TMR_W-1:0]      r_timer;

    // Output register
    logic [DATA_WIDTH-1:0] r_out_x;
    logic [DATA_WIDTH-1:0] r_out_y;
    logic [LANES-1:0]      r_out_mask;
    logic [1:0]            r_out_mode;
    logic                  r_out_valid;

    logic                  w_out_free;
    logic                  w_accept;
    logic                  w_mismatch;
    logic                  w_close_pend;
    logic                  w_close_new;
    logic                  w_idle;
    logic [DATA_WIDTH-1:0] w_old_x;
    logic [DATA_WIDTH-1:0] w_old_y;
    logic [DATA_WIDTH-1:0] w_new_x;
    logic [DATA_WIDTH-1:0] w_new_y;
    logic [LANES-1:0]      w_new_mask;
    logic [1:0]            w_new_mode;
    logic [DATA_WIDTH-1:0] w_fresh_x;
    logic [DATA_WIDTH-1:0] w_fresh_y;

    // Upstream may only push while the output slot can take a word and nothing is waiting to move
    assign w_out_free   = !r_out_valid || out_ready;
    assign in_ready     = w_out_free && !r_pending;
    assign w_accept     = in_valid && in_ready;
    assign w_mismatch   = (r_cnt != '0) && (in_mode != r_asm_mode);
    assign w_close_pend = r_pending && w_out_free;
    assign w_close_new  = (r_cnt == CNT_LAST) || in_last;
    assign w_idle       = (r_cnt != '0) && !r_pending && !w_accept;

    assign out_valid = r_out_valid;
    assign x_out     = r_out_x;
    assign y_out     = r_out_y;
    assign lane_mask = r_out_mask;
    assign mode_out  = r_out_mode;

    // Padded views of the assembly: as it stands, with the incoming pair inserted, and a fresh one-lane group
    always_comb begin
        w_old_x    = '0;
        w_old_y    = '0;
        w_new_x    = '0;
        w_new_y    = '0;
        w_new_mask = '0;
        w_new_mode = (r_cnt == '0) ? in_mode : r_asm_mode;
        w_fresh_x  = {{(LANES-1){PAD_VALUE}}, in_a};
        w_fresh_y  = {{(LANES-1){PAD_VALUE}}, in_b};
        for (int i = 0; i < LANES; i++) begin
            w_old_x[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
                r_asm_mask[i] ? r_asm_x[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] : PAD_VALUE;
            w_old_y[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
                r_asm_mask[i] ? r_asm_y[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] : PAD_VALUE;
            if (r_cnt == CNT_W'(i)) begin
                w_new_x[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] = in_a;
                w_new_y[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] = in_b;
                w_new_mask[i] = 1'b1;
            end else begin
                w_new_x[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] = w_old_x[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
                w_new_y[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] = w_old_y[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
                w_new_mask[i] = r_asm_mask[i];
            end
        end
    end

    // Assembly, close decisions, idle timer and the output register, all updated together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_asm_x     <= '0;
            r_asm_y     <= '0;
            r_asm_mask  <= '0;
            r_asm_mode  <= '0;
            r_cnt       <= '0;
            r_pending   <= 1'b0;
            r_timer     <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_mask  <= '0;
            r_out_mode  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_close_pend) begin
                r_out_x     <= w_old_x;
                r_out_y     <= w_old_y;
                r_out_mask  <= r_asm_mask;
                r_out_mode  <= r_asm_mode;
                r_out_valid <= 1'b1;
                r_asm_mask  <= '0;
                r_cnt       <= '0;
                r_pending   <= 1'b0;
                r_timer     <= '0;
            end else if (w_accept) begin
                r_timer <= '0;
                if (w_mismatch) begin
                    r_out_x     <= w_old_x;
                    r_out_y     <= w_old_y;
                    r_out_mask  <= r_asm_mask;
                    r_out_mode  <= r_asm_mode;
                    r_out_valid <= 1'b1;
                    r_asm_x     <= w_fresh_x;
                    r_asm_y     <= w_fresh_y;
                    r_asm_mask  <= LANES'(1);
                    r_asm_mode  <= in_mode;
                    r_cnt       <= CNT_W'(1);
                    r_pending   <= in_last;
                end else if (w_close_new) begin
                    r_out_x     <= w_new_x;
                    r_out_y     <= w_new_y;
                    r_out_mask  <= w_new_mask;
                    r_out_mode  <= w_new_mode;
                    r_out_valid <= 1'b1;
                    r_asm_mask  <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_asm_x    <= w_new_x;
                    r_asm_y    <= w_new_y;
                    r_asm_mask <= w_new_mask;
                    r_asm_mode <= w_new_mode;
                    r_cnt      <= r_cnt + 1'b1;
                end
            end else if (TMR_EN && w_idle) begin
                if (r_timer == TMR_LAST) begin
                    r_pending <= 1'b1;
                    r_timer   <= '0;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lse_simd_4x6b_feeder.sv
// tb_lse_simd_4x6b_feeder
// Drives directed and random pair streams into the feeder and compares the emitted
// words against a transaction-level grouping model kept in this file.
module tb_lse_simd_4x6b_feeder;

    localparam int T = 16;

    typedef struct packed {
        logic [23:0] x;
        logic [23:0] y;
        logic [3:0]  mask;
        logic [1:0]  mode;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_a;
    logic [5:0]  in_b;
    logic [1:0]  in_mode;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] x_out;
    logic [23:0] y_out;
    logic [3:0]  lane_mask;
    logic [1:0]  mode_out;

    logic        iv0, rdy0, il0, ov0, or0;
    logic [5:0]  ia0, ib0;
    logic [1:0]  im0, md0;
    logic [23:0] x0, y0;
    logic [3:0]  lm0;

    word_t       expq[$];
    word_t       gotq[$];
    logic [5:0]  ga[$];
    logic [5:0]  gb[$];
    logic [1:0]  gmode;
    int          glast;
    int          cyc;
    int          errors;
    int          checks;
    bit          randReady;

    always #5 clk = ~clk;

    lse_simd_4x6b_feeder #(.IDLE_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .y_out(y_out),
        .lane_mask(lane_mask), .mode_out(mode_out)
    );

    lse_simd_4x6b_feeder #(.IDLE_TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0),
        .in_a(ia0), .in_b(ib0), .in_mode(im0), .in_last(il0),
        .out_valid(ov0), .out_ready(or0), .x_out(x0), .y_out(y0),
        .lane_mask(lm0), .mode_out(md0)
    );

    // Reference grouping model: pairs collect into a group until four, last, a mode change or a long gap
    function automatic word_t pack_group();
        word_t w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < ga.size()) begin
                w.x[i*6 +: 6] = ga[i];
                w.y[i*6 +: 6] = gb[i];
                w.mask[i]     = 1'b1;
            end else begin
                w.x[i*6 +: 6] = 6'h20;
                w.y[i*6 +: 6] = 6'h20;
                w.mask[i]     = 1'b0;
            end
        end
        w.mode = gmode;
        return w;
    endfunction

    function automatic void model_close();
        if (ga.size() > 0) begin
            expq.push_back(pack_group());
            ga.delete();
            gb.delete();
        end
    endfunction

    function automatic void model_timeout(int c);
        if (ga.size() > 0 && T > 0 && (c - glast) > T) model_close();
    endfunction

    function automatic void model_accept(logic [5:0] a, logic [5:0] b, logic [1:0] m, logic l, int c);
        if (ga.size() > 0 && m != gmode) model_close();
        if (ga.size() == 0) gmode = m;
        ga.push_back(a);
        gb.push_back(b);
        glast = c;
        if (ga.size() == 4 || l) model_close();
    endfunction

    function automatic void model_reset();
        ga.delete();
        gb.delete();
        expq.delete();
        gotq.delete();
    endfunction

    // One clock: sample handshakes just before the edge, record fired words, feed the model
    task automatic step(output bit acc);
        word_t g;
        if (randReady) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            g.x = x_out; g.y = y_out; g.mask = lane_mask; g.mode = mode_out;
            gotq.push_back(g);
        end
        model_timeout(cyc);
        if (acc) model_accept(in_a, in_b, in_mode, in_last, cyc);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send_pair(input logic [5:0] a, input logic [5:0] b, input logic [1:0] m,
                             input logic l, output int waited);
        bit acc;
        waited = 0;
        acc = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_mode = m; in_last = l;
        while (!acc && waited < 200) begin
            step(acc);
            waited++;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("[TB] FAIL send_pair accept: not accepted after %0d cycles, required within 200", waited);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        repeat (n) step(acc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; in_a = 0; in_b = 0; in_mode = 0; in_last = 0; out_ready = 0;
        iv0 = 0; ia0 = 0; ib0 = 0; im0 = 0; il0 = 0; or0 = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b want 0", out_valid); end
        checks++; if (x_out !== 24'h0) begin errors++; $display("[TB] FAIL reset x_out: got %h want 0", x_out); end
        checks++; if (y_out !== 24'h0) begin errors++; $display("[TB] FAIL reset y_out: got %h want 0", y_out); end
        checks++; if (lane_mask !== 4'h0) begin errors++; $display("[TB] FAIL reset lane_mask: got %b want 0", lane_mask); end
        checks++; if (mode_out !== 2'd0) begin errors++; $display("[TB] FAIL reset mode_out: got %0d want 0", mode_out); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset in_ready: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_full_words();
        int w;
        int total;
        model_reset();
        out_ready = 1'b1;
        total = 0;
        for (int i = 1; i <= 8; i++) begin
            send_pair(6'(i), 6'(i + 8), 2'd0, 1'b0, w);
            total += w;
            if (i == 3) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_words early valid: got %b want 0", out_valid); end
            end
            if (i == 4 || i == 8) begin
                checks++;
                if (out_valid !== 1'b1 || lane_mask !== 4'hF ||
                    x_out !== {6'(i), 6'(i - 1), 6'(i - 2), 6'(i - 3)}) begin
                    errors++;
                    $display("[TB] FAIL full_words word after pair %0d: got v=%b m=%b x=%h want v=1 m=1111 x=%h",
                             i, out_valid, lane_mask, x_out, {6'(i), 6'(i - 1), 6'(i - 2), 6'(i - 3)});
                end
            end
        end
        checks++; if (total != 8) begin errors++; $display("[TB] FAIL full_words throughput: got %0d cycles want 8", total); end
        idle(3);
        checks++; if (gotq.size() != 2) begin errors++; $display("[TB] FAIL full_words count: got %0d want 2", gotq.size()); end
        for (int k = 0; k < gotq.size() && k < expq.size(); k++) begin
            checks++;
            if (gotq[k] !== expq[k]) begin
                errors++;
                $display("[TB] FAIL full_words word%0d: got %h want %h", k, gotq[k], expq[k]);
            end
        end
    endtask

    task automatic test_last_partial();
        int w;
        model_reset();
        out_ready = 1'b1;
        send_pair(6'd3, 6'd13, 2'd1, 1'b0, w);
        send_pair(6'd4, 6'd14, 2'd1, 1'b0, w);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL last_partial early valid: got %b want 0", out_valid); end
        send_pair(6'd5, 6'd15, 2'd1, 1'b1, w);
        checks++; if (x_out !== {6'h20, 6'd5, 6'd4, 6'd3}) begin errors++; $display("[TB] FAIL last_partial x_out: got %h want %h", x_out, {6'h20, 6'd5, 6'd4, 6'd3}); end
        checks++; if (y_out !== {6'h20, 6'd15, 6'd14, 6'd13}) begin errors++; $display("[TB] FAIL last_partial y_out: got %h want %h", y_out, {6'h20, 6'd15, 6'd14, 6'd13}); end
        checks++; if (lane_mask !== 4'b0111 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL last_partial mask: got v=%b m=%b want v=1 m=0111", out_valid, lane_mask); end
        idle(2);
        checks++; if (gotq.size() != expq.size()) begin errors++; $display("[TB] FAIL last_partial count: got %0d want %0d", gotq.size(), expq.size()); end
        for (int k = 0; k < gotq.size() && k < expq.size(); k++) begin
            checks++;
            if (gotq[k] !== expq[k]) begin errors++; $display("[TB] FAIL last_partial word%0d: got %h want %h", k, gotq[k], expq[k]); end
        end
    endtask

    task automatic test_mode_change();
        int w;
        model_reset();
        out_ready = 1'b1;
        send_pair(6'd10, 6'd20, 2'd0, 1'b0, w);
        send_pair(6'd11, 6'd21, 2'd0, 1'b0, w);
        send_pair(6'd12, 6'd22, 2'd1, 1'b1, w);
        checks++; if (w != 1) begin errors++; $display("[TB] FAIL mode_change accept delay: got %0d want 1", w); end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || lane_mask !== 4'b0011 || mode_out !== 2'd0) begin
            errors++;
            $display("[TB] FAIL mode_change word1: got rdy=%b v=%b m=%b md=%0d want rdy=0 v=1 m=0011 md=0",
                     in_ready, out_valid, lane_mask, mode_out);
        end
        idle(1);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || lane_mask !== 4'b0001 || mode_out !== 2'd1 ||
            x_out !== {6'h20, 6'h20, 6'h20, 6'd12}) begin
            errors++;
            $display("[TB] FAIL mode_change word2: got rdy=%b v=%b m=%b md=%0d x=%h want rdy=1 v=1 m=0001 md=1 x=%h",
                     in_ready, out_valid, lane_mask, mode_out, x_out, {6'h20, 6'h20, 6'h20, 6'd12});
        end
        idle(2);
        checks++; if (gotq.size() != 2) begin errors++; $display("[TB] FAIL mode_change count: got %0d want 2", gotq.size()); end
        for (int k = 0; k < gotq.size() && k < expq.size(); k++) begin
            checks++;
            if (gotq[k] !== expq[k]) begin errors++; $display("[TB] FAIL mode_change word%0d: got %h want %h", k, gotq[k], expq[k]); end
        end
    endtask

    task automatic test_backpressure();
        int w;
        bit acc;
        logic [23:0] expX;
        model_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_pair(6'(30 + i), 6'(i), 2'd3, 1'b0, w);
        expX = {6'd34, 6'd33, 6'd32, 6'd31};
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL backpressure stall: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready); end
        in_valid = 1'b1; in_a = 6'd35; in_b = 6'd5; in_mode = 2'd3; in_last = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(acc);
            checks++;
            if (acc || out_valid !== 1'b1 || x_out !== expX || lane_mask !== 4'hF || mode_out !== 2'd3) begin
                errors++;
                $display("[TB] FAIL backpressure hold cycle %0d: got acc=%b v=%b x=%h m=%b want acc=0 v=1 x=%h m=1111",
                         c, acc, out_valid, x_out, lane_mask, expX);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send_pair(6'd35, 6'd5, 2'd3, 1'b0, w);
        checks++; if (w != 1) begin errors++; $display("[TB] FAIL backpressure resume: got %0d cycles want 1", w); end
        send_pair(6'd36, 6'd6, 2'd3, 1'b1, w);
        idle(3);
        checks++; if (gotq.size() != 2) begin errors++; $display("[TB] FAIL backpressure count: got %0d want 2", gotq.size()); end
        for (int k = 0; k < gotq.size() && k < expq.size(); k++) begin
            checks++;
            if (gotq[k] !== expq[k]) begin errors++; $display("[TB] FAIL backpressure word%0d: got %h want %h", k, gotq[k], expq[k]); end
        end
    endtask

    task automatic test_timeout();
        int w;
        int k;
        bit acc;
        model_reset();
        out_ready = 1'b1;
        send_pair(6'd9, 6'd19, 2'd2, 1'b0, w);
        k = 0;
        in_valid = 1'b0;
        while (!out_valid && k < 40) begin
            step(acc);
            k++;
        end
        checks++; if (k != 17) begin errors++; $display("[TB] FAIL timeout latency: got %0d cycles want 17", k); end
        checks++;
        if (lane_mask !== 4'b0001 || x_out !== {6'h20, 6'h20, 6'h20, 6'd9} || mode_out !== 2'd2) begin
            errors++;
            $display("[TB] FAIL timeout word: got m=%b x=%h md=%0d want m=0001 x=%h md=2",
                     lane_mask, x_out, mode_out, {6'h20, 6'h20, 6'h20, 6'd9});
        end
        idle(2);
        checks++; if (gotq.size() != expq.size()) begin errors++; $display("[TB] FAIL timeout count: got %0d want %0d", gotq.size(), expq.size()); end
        for (int j = 0; j < gotq.size() && j < expq.size(); j++) begin
            checks++;
            if (gotq[j] !== expq[j]) begin errors++; $display("[TB] FAIL timeout word%0d: got %h want %h", j, gotq[j], expq[j]); end
        end
    endtask

    task automatic test_timeout_disabled();
        bit seen;
        iv0 = 1'b1; ia0 = 6'd7; ib0 = 6'd8; im0 = 2'd1; il0 = 1'b0; or0 = 1'b1;
        #1;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("[TB] FAIL no_timeout ready: got %b want 1", rdy0); end
        @(posedge clk);
        @(negedge clk);
        iv0 = 1'b0;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (ov0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL no_timeout idle word: got valid=1 want none"); end
        iv0 = 1'b1; ia0 = 6'd9; ib0 = 6'd10; il0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv0 = 1'b0; il0 = 1'b0;
        #1;
        checks++;
        if (ov0 !== 1'b1 || lm0 !== 4'b0011 || x0 !== {6'h20, 6'h20, 6'd9, 6'd7} || md0 !== 2'd1) begin
            errors++;
            $display("[TB] FAIL no_timeout close: got v=%b m=%b x=%h md=%0d want v=1 m=0011 x=%h md=1",
                     ov0, lm0, x0, md0, {6'h20, 6'h20, 6'd9, 6'd7});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_group();
        int w;
        model_reset();
        out_ready = 1'b1;
        send_pair(6'd1, 6'd2, 2'd0, 1'b0, w);
        send_pair(6'd3, 6'd4, 2'd0, 1'b0, w);
        send_pair(6'd5, 6'd6, 2'd1, 1'b0, w);
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid setup: got v=%b want 1", out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || lane_mask !== 4'h0) begin errors++; $display("[TB] FAIL reset_mid clear: got v=%b m=%b want v=0 m=0000", out_valid, lane_mask); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_pair(6'(40 + i), 6'(50 + i), 2'd2, 1'b0, w);
        idle(25);
        checks++; if (gotq.size() != 1) begin errors++; $display("[TB] FAIL reset_mid count: got %0d want 1", gotq.size()); end
        for (int k = 0; k < gotq.size() && k < expq.size(); k++) begin
            checks++;
            if (gotq[k] !== expq[k]) begin errors++; $display("[TB] FAIL reset_mid word%0d: got %h want %h", k, gotq[k], expq[k]); end
        end
    endtask

    task automatic test_random();
        int w;
        int r;
        logic [1:0] curMode;
        logic l;
        model_reset();
        curMode = 2'd0;
        randReady = 1'b1;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 15);
            if (r == 0) idle(20);
            else idle(r % 3);
            if ($urandom_range(0, 4) == 0) curMode = 2'($urandom_range(0, 3));
            l = (n == 79) || ($urandom_range(0, 7) == 0);
            send_pair(6'($urandom), 6'($urandom), curMode, l, w);
        end
        randReady = 1'b0;
        out_ready = 1'b1;
        idle(40);
        checks++; if (gotq.size() != expq.size()) begin errors++; $display("[TB] FAIL random count: got %0d want %0d", gotq.size(), expq.size()); end
        for (int k = 0; k < gotq.size() && k < expq.size(); k++) begin
            checks++;
            if (gotq[k] !== expq[k]) begin errors++; $display("[TB] FAIL random word%0d: got %h want %h", k, gotq[k], expq[k]); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        glast = 0;
        gmode = 2'd0;
        randReady = 1'b0;
        test_reset();
        test_full_words();
        test_last_partial();
        test_mode_change();
        test_backpressure();
        test_timeout();
        test_timeout_disabled();
        test_reset_mid_group();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion within 2000000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
